// File: rtl/data_mem_io_pkg.sv
// Shared constants for the data-side memory subsystem: I/O register offsets
// and STATUS bit positions.
package data_mem_io_pkg;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CYCLE  = 8'h08;
    localparam logic [7:0] OFF_CMP    = 8'h0C;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_MATCH = 3;

endpackage

// File: rtl/data_mem_io_sync_fifo.sv
// Synchronous FIFO with registered storage and a masked head output.
// DATA_MEM_IO_COUNT_EN adds an occupancy counter and a count port.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
`ifdef DATA_MEM_IO_COUNT_EN
    ,
    output logic [CW-1:0]    count
`endif
);

`ifdef DATA_MEM_IO_COUNT_EN
    localparam int PW = AW;
`else
    localparam int PW = AW + 1;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef DATA_MEM_IO_COUNT_EN
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
`else
    // Extra wrap bit distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
`endif

endmodule

// File: rtl/data_mem_io.sv
// Data-side memory: word RAM, console TX FIFO and cycle counter/compare,
// read combinationally. DATA_MEM_IO_COUNT_EN reports occupancy in STATUS[15:8].
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int          MEM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int          RAM_AW    = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

    logic [31:0]       ram [MEM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_hit;
    logic              io_hit;
    logic [7:0]        io_off;
    logic              wr_en;
    logic              wr_txdata;
    logic              wr_status;
    logic              wr_cycle;
    logic              wr_cmp;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              ovf_set;
    logic [31:0]       cycle_q;
    logic [31:0]       cmp_q;
    logic              ovf_q;
    logic              match_q;
    logic [31:0]       status_word;

    assign ram_hit = ({1'b0, addr} < RAM_BYTES);
    assign ram_idx = addr[RAM_AW+1:2];
    assign io_hit  = (addr[31:8] == IO_BASE[31:8]);
    assign io_off  = addr[7:0];

    // Writes presented while reset is asserted never reach any state.
    assign wr_en     = we && reset;
    assign wr_txdata = wr_en && io_hit && (io_off == OFF_TXDATA);
    assign wr_status = wr_en && io_hit && (io_off == OFF_STATUS);
    assign wr_cycle  = wr_en && io_hit && (io_off == OFF_CYCLE);
    assign wr_cmp    = wr_en && io_hit && (io_off == OFF_CMP);

    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) ram[ram_idx] <= wdata;
    end

    assign tx_valid = !fifo_empty;
    assign fifo_pop = tx_valid && tx_ready;

`ifdef DATA_MEM_IO_COUNT_EN
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
`ifdef DATA_MEM_IO_COUNT_EN
        ,
        .count (fifo_count)
`endif
    );

    // A push into a full FIFO only overflows if nothing leaves on the same edge.
    assign ovf_set = wr_txdata && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            ovf_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            cycle_q <= wr_cycle ? wdata : cycle_q + 32'd1;
            if (wr_cmp) cmp_q <= wdata;
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (wr_status && wdata[ST_OVF])
                ovf_q <= 1'b0;
            if (cycle_q == cmp_q)
                match_q <= 1'b1;
            else if (wr_status && wdata[ST_MATCH])
                match_q <= 1'b0;
        end
    end

    always_comb begin
        status_word           = '0;
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_EMPTY] = fifo_empty;
        status_word[ST_OVF]   = ovf_q;
        status_word[ST_MATCH] = match_q;
`ifdef DATA_MEM_IO_COUNT_EN
        status_word[15:8]     = 8'(fifo_count);
`endif
    end

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = ram[ram_idx];
        end else if (io_hit) begin
            case (io_off)
                OFF_STATUS: rdata = status_word;
                OFF_CYCLE:  rdata = cycle_q;
                OFF_CMP:    rdata = cmp_q;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: RAM decode, TX FIFO ordering/overflow,
// cycle counter compare and mid-transfer reset.
module tb_data_mem_io;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_CY  = 32'hFFFF_0008;
    localparam logic [31:0] A_CMP = 32'hFFFF_000C;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];

    data_mem_io dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    // Clock/reset: inputs change on negedge, samples taken between edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted TX byte must match the head of exp_q.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        #4;
        if (reset && tx_valid && tx_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_pop: got %h, expected no byte", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    n_err++;
                    $display("FAIL tx_pop: got %h, expected %h", tx_data, exp_b);
                end
            end
        end
    end

    function automatic logic [31:0] exp_st(input bit f, input bit e, input bit o,
                                           input bit m, input int occ);
        logic [31:0] s;
        s = {28'd0, m, o, e, f};
`ifdef DATA_MEM_IO_COUNT_EN
        s[15:8] = 8'(occ);
`endif
        return s;
    endfunction

    // Driver tasks
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (tx_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: tx_valid got %b, expected 0 within 50 cycles", name, tx_valid);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0; we = 1'b0; tx_ready = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        rd(A_CY, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_cycle: got %h, expected %h", d, 32'd0); end
        rd(A_CMP, d);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_cmp: got %h, expected ffffffff", d); end
        rd(A_ST, d);
        n_vec++; if (d !== exp_st(0, 1, 0, 0, 0)) begin n_err++; $display("FAIL rst_status: got %h, expected %h", d, exp_st(0, 1, 0, 0, 0)); end
        n_vec++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx: got v=%b d=%h, expected v=0 d=00", tx_valid, tx_data); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram();
        logic [31:0] d;
        logic [31:0] rnd_val [4];
        int          rnd_idx [4];
        wr(32'h10, 32'h1234_5678);
        rd(32'h10, d);
        n_vec++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL ram_rd10: got %h, expected 12345678", d); end
        rd(32'h13, d);
        n_vec++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL ram_rd13: got %h, expected 12345678", d); end
        wr(32'h8000_0000, 32'hDEAD_BEEF);
        rd(32'h8000_0000, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL unmapped_rd: got %h, expected 0", d); end
        wr(32'h3FC, 32'hCAFE_F00D);
        rd(32'h3FC, d);
        n_vec++; if (d !== 32'hCAFE_F00D) begin n_err++; $display("FAIL ram_last: got %h, expected cafef00d", d); end
        rd(32'h400, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ram_past_end: got %h, expected 0", d); end
        rd(A_TX + 32'h10, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL io_other: got %h, expected 0", d); end
        // Same-cycle read of the word being written sees the old contents.
        wr(32'h14, 32'hAAAA_0001);
        addr = 32'h14; wdata = 32'hBBBB_0002; we = 1'b1;
        #1;
        n_vec++; if (rdata !== 32'hAAAA_0001) begin n_err++; $display("FAIL rd_during_wr: got %h, expected aaaa0001", rdata); end
        @(negedge clk);
        we = 1'b0;
        rd(32'h14, d);
        n_vec++; if (d !== 32'hBBBB_0002) begin n_err++; $display("FAIL wr_after: got %h, expected bbbb0002", d); end
        for (int i = 0; i < 4; i++) begin
            rnd_idx[i] = $urandom_range(8, 60) + i * 64;
            rnd_val[i] = $urandom;
            wr(32'(rnd_idx[i] * 4), rnd_val[i]);
        end
        for (int i = 0; i < 4; i++) begin
            rd(32'(rnd_idx[i] * 4), d);
            n_vec++; if (d !== rnd_val[i]) begin n_err++; $display("FAIL ram_rand[%0d]: got %h, expected %h", i, d, rnd_val[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h41 + i));
            wr(A_TX, 32'(8'h41 + i));
        end
        rd(A_ST, d);
        n_vec++; if (d !== exp_st(1, 0, 0, 0, 8)) begin n_err++; $display("FAIL ovf_full: got %h, expected %h", d, exp_st(1, 0, 0, 0, 8)); end
        rd(A_TX, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL txdata_rd: got %h, expected 0", d); end
        wr(A_TX, 32'h49);
        rd(A_ST, d);
        n_vec++; if (d !== exp_st(1, 0, 1, 0, 8)) begin n_err++; $display("FAIL ovf_set: got %h, expected %h", d, exp_st(1, 0, 1, 0, 8)); end
        n_vec++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL ovf_head: got %h, expected 41", tx_data); end
        wr(A_ST, 32'h4);
        rd(A_ST, d);
        n_vec++; if (d !== exp_st(1, 0, 0, 0, 8)) begin n_err++; $display("FAIL ovf_w1c: got %h, expected %h", d, exp_st(1, 0, 0, 0, 8)); end
        @(negedge clk);
        tx_ready = 1'b1;
        wait_empty("ovf");
        tx_ready = 1'b0;
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ovf_left: got %0d bytes outstanding, expected 0", exp_q.size()); end
    endtask

    task automatic test_no_bypass();
        tx_ready = 1'b1;
        addr = A_TX; wdata = 32'h55; we = 1'b1;
        exp_q.push_back(8'h55);
        #1;
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL bypass_same: got v=%b, expected 0", tx_valid); end
        @(negedge clk);
        we = 1'b0;
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin n_err++; $display("FAIL bypass_next: got v=%b d=%h, expected v=1 d=55", tx_valid, tx_data); end
        @(negedge clk);
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL bypass_gone: got v=%b, expected 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h90 + i));
            wr(A_TX, 32'(8'h90 + i));
        end
        // Push into a full FIFO on the same edge as a pop.
        addr = A_TX; wdata = 32'h99; we = 1'b1; tx_ready = 1'b1;
        exp_q.push_back(8'h99);
        @(negedge clk);
        we = 1'b0; tx_ready = 1'b0;
        rd(A_ST, d);
        n_vec++; if (d !== exp_st(1, 0, 0, 0, 8)) begin n_err++; $display("FAIL full_pushpop: got %h, expected %h", d, exp_st(1, 0, 0, 0, 8)); end
        n_vec++; if (tx_data !== 8'h91) begin n_err++; $display("FAIL full_head: got %h, expected 91", tx_data); end
        @(negedge clk);
        tx_ready = 1'b1;
        wait_empty("b2b");
        tx_ready = 1'b0;
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_left: got %0d bytes outstanding, expected 0", exp_q.size()); end
    endtask

    task automatic test_cycle_cmp();
        logic [31:0] d;
        logic [31:0] e;
        wr(A_CMP, 32'h1);
        wr(A_ST, 32'h8);
        rd(A_CMP, d);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL cmp_rd: got %h, expected 1", d); end
        wr(A_CY, 32'hFFFF_FFFE);
        for (int k = 0; k < 6; k++) begin
            e = 32'hFFFF_FFFE + 32'(k);
            rd(A_CY, d);
            n_vec++; if (d !== e) begin n_err++; $display("FAIL cycle[%0d]: got %h, expected %h", k, d, e); end
            rd(A_ST, d);
            e = exp_st(0, 1, 0, k >= 4, 0);
            n_vec++; if (d !== e) begin n_err++; $display("FAIL match[%0d]: got %h, expected %h", k, d, e); end
            @(negedge clk);
        end
        wr(A_ST, 32'h8);
        rd(A_ST, d);
        n_vec++; if (d !== exp_st(0, 1, 0, 0, 0)) begin n_err++; $display("FAIL match_w1c: got %h, expected %h", d, exp_st(0, 1, 0, 0, 0)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'hA0 + i));
            wr(A_TX, 32'(8'hA0 + i));
        end
        wr(A_CY, 32'd100);
        reset = 1'b0;
        addr = 32'h10; wdata = 32'h0000_DEAD; we = 1'b1;
        @(negedge clk);
        reset = 1'b1; we = 1'b0;
        exp_q.delete();
        rd(A_CY, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL mid_cycle: got %h, expected 0", d); end
        n_vec++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL mid_tx: got v=%b d=%h, expected v=0 d=00", tx_valid, tx_data); end
        rd(A_CMP, d);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mid_cmp: got %h, expected ffffffff", d); end
        rd(A_ST, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL mid_status: got %h, expected 2", d); end
        rd(32'h10, d);
        n_vec++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL mid_ram: got %h, expected 12345678", d); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ram();
        test_overflow();
        test_no_bypass();
        test_back_to_back();
        test_cycle_cmp();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
